sprite_queue_feeder: RTL and testbench

//  Producer end of the sprite draw queue. Assembles sprite draw commands from a host byte stream (SPI/UART front end).

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_cmd_fifo.sv | 71 +++++++
 rtl/sprite_queue_feeder.sv | 123 ++++++++++++
 tb/tb_sprite_queue_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite command types and host-protocol constants for the sprite draw queue.
package sprite_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } sprite_cmd_t;

    // Payload bytes following the header; also documented in the host firmware protocol.
    localparam int         SPRITE_CMD_BYTES  = 6;
    localparam logic [7:0] SPRITE_CMD_HEADER = 8'hA5;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Show-ahead FIFO of sprite commands: head is mem[rd_ptr] whenever not empty, zero otherwise.
module sprite_cmd_fifo
    import sprite_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   fb_resetting,
    input  logic                   push,
    input  sprite_cmd_t            push_data,
    input  logic                   pop,
    output sprite_cmd_t            head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    sprite_cmd_t   mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    // Zero the head while empty so the outputs are defined right after a flush.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sprite_queue_feeder.sv
// Assembles 7-byte sprite commands from the host byte stream and queues them for the renderers.
module sprite_queue_feeder
    import sprite_pkg::*;
#(
    parameter int         DEPTH  = 64,
    parameter logic [7:0] HEADER = SPRITE_CMD_HEADER
) (
    input  logic                   clock,
    input  logic                   fb_resetting,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   sprite_queue_dequeue,
    output logic                   sprite_queue_is_empty,
    output logic [7:0]             sprite_queue_sprite_id,
    output logic [15:0]            sprite_queue_sprite_x,
    output logic [15:0]            sprite_queue_sprite_y,
    output logic [7:0]             sprite_queue_sprite_scale,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   underflow,
    output logic [7:0]             frame_err_cnt
);

    localparam int BUF_W = $bits(sprite_cmd_t) - 8;

    feeder_state_t state_q, state_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [BUF_W-1:0] field_buf_q, field_buf_d;
    logic             underflow_q, underflow_d;
    logic [7:0]       frame_err_cnt_q, frame_err_cnt_d;

    logic        accept;
    logic        last_byte;
    logic        fifo_push;
    logic        fifo_full;
    logic        fifo_empty;
    sprite_cmd_t push_cmd;
    sprite_cmd_t fifo_head;

    assign last_byte = (state_q == ST_COLLECT) && (byte_idx_q == 3'(SPRITE_CMD_BYTES - 1));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            state_q         <= ST_HUNT;
            byte_idx_q      <= '0;
            field_buf_q     <= '0;
            underflow_q     <= 1'b0;
            frame_err_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            byte_idx_q      <= byte_idx_d;
            field_buf_q     <= field_buf_d;
            underflow_q     <= underflow_d;
            frame_err_cnt_q <= frame_err_cnt_d;
        end
    end

    // Inside COLLECT every byte is payload, including one equal to HEADER.
    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        field_buf_d = field_buf_q;
        if (accept) begin
            case (state_q)
                ST_HUNT: begin
                    if (in_data == HEADER) begin
                        state_d    = ST_COLLECT;
                        byte_idx_d = '0;
                    end
                end
                ST_COLLECT: begin
                    field_buf_d = {field_buf_q[BUF_W-9:0], in_data};
                    if (last_byte) begin
                        state_d    = ST_HUNT;
                        byte_idx_d = '0;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Only the final byte stalls, and only on a registered full flag.
    always_comb begin
        in_ready  = !(last_byte && fifo_full);
        fifo_push = accept && last_byte;
        push_cmd  = {field_buf_q, in_data};
    end

    always_comb begin
        underflow_d     = underflow_q || (sprite_queue_dequeue && fifo_empty);
        frame_err_cnt_d = frame_err_cnt_q;
        if (accept && (state_q == ST_HUNT) && (in_data != HEADER) && (frame_err_cnt_q != 8'hFF)) begin
            frame_err_cnt_d = frame_err_cnt_q + 8'd1;
        end
    end

    sprite_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .fb_resetting (fb_resetting),
        .push         (fifo_push),
        .push_data    (push_cmd),
        .pop          (sprite_queue_dequeue),
        .head         (fifo_head),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .count        (queue_count)
    );

    assign sprite_queue_is_empty     = fifo_empty;
    assign sprite_queue_sprite_id    = fifo_head.id;
    assign sprite_queue_sprite_x     = fifo_head.x;
    assign sprite_queue_sprite_y     = fifo_head.y;
    assign sprite_queue_sprite_scale = fifo_head.scale;
    assign underflow                 = underflow_q;
    assign frame_err_cnt             = frame_err_cnt_q;

endmodule

// File: tb/tb_sprite_queue_feeder.sv
// Directed and randomised checks of the sprite queue feeder against hand-computed values and a small model.
module tb_sprite_queue_feeder;

    localparam int DEPTH = 64;

    logic        clock = 1'b0;
    logic        fb_resetting;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        sprite_queue_dequeue;
    logic        sprite_queue_is_empty;
    logic [7:0]  sprite_queue_sprite_id;
    logic [15:0] sprite_queue_sprite_x;
    logic [15:0] sprite_queue_sprite_y;
    logic [7:0]  sprite_queue_sprite_scale;
    logic [6:0]  queue_count;
    logic        underflow;
    logic [7:0]  frame_err_cnt;
    logic [47:0] head;

    int n_cmp = 0;
    int n_mis = 0;

    // Soak model state
    logic [47:0] exp_q[$];
    bit          m_collect;
    int          m_idx;
    logic [39:0] m_buf;
    int          m_err;
    bit          m_under;

    always #5 clock = ~clock;

    assign head = {sprite_queue_sprite_id, sprite_queue_sprite_x, sprite_queue_sprite_y, sprite_queue_sprite_scale};

    sprite_queue_feeder #(
        .DEPTH  (DEPTH),
        .HEADER (8'hA5)
    ) dut (
        .clock                     (clock),
        .fb_resetting              (fb_resetting),
        .in_valid                  (in_valid),
        .in_data                   (in_data),
        .in_ready                  (in_ready),
        .sprite_queue_dequeue      (sprite_queue_dequeue),
        .sprite_queue_is_empty     (sprite_queue_is_empty),
        .sprite_queue_sprite_id    (sprite_queue_sprite_id),
        .sprite_queue_sprite_x     (sprite_queue_sprite_x),
        .sprite_queue_sprite_y     (sprite_queue_sprite_y),
        .sprite_queue_sprite_scale (sprite_queue_sprite_scale),
        .queue_count               (queue_count),
        .underflow                 (underflow),
        .frame_err_cnt             (frame_err_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        fb_resetting         = 1'b1;
        in_valid             = 1'b0;
        sprite_queue_dequeue = 1'b0;
        @(posedge clock);
        @(negedge clock);
        fb_resetting = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Holds the byte until accepted; returns 1 ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 200 && !done; t++) begin
            if (in_ready) done = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check_val("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_pkt(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y, input logic [7:0] sc);
        send_byte(8'hA5);
        send_byte(id);
        send_byte(x[15:8]);
        send_byte(x[7:0]);
        send_byte(y[15:8]);
        send_byte(y[7:0]);
        send_byte(sc);
    endtask

    task automatic pop_one();
        sprite_queue_dequeue = 1'b1;
        @(posedge clock);
        #1;
        sprite_queue_dequeue = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        bit         dq;
        bit         acc;
        bit         m_ready;

        // Reset values, checked while reset is held
        fb_resetting         = 1'b1;
        in_valid             = 1'b0;
        in_data              = 8'h00;
        sprite_queue_dequeue = 1'b0;
        #12;
        check_val("rst_empty", 64'(sprite_queue_is_empty), 64'd1);
        check_val("rst_count", 64'(queue_count), 64'd0);
        check_val("rst_ready", 64'(in_ready), 64'd1);
        check_val("rst_under", 64'(underflow), 64'd0);
        check_val("rst_ferr", 64'(frame_err_cnt), 64'd0);
        check_val("rst_head", 64'(head), 64'd0);
        @(negedge clock);
        fb_resetting = 1'b0;
        @(posedge clock);
        #1;

        // Single packet, visible the cycle after its last byte
        send_pkt(8'h07, 16'h0190, 16'h00C8, 8'h10);
        check_val("p1_empty", 64'(sprite_queue_is_empty), 64'd0);
        check_val("p1_id", 64'(sprite_queue_sprite_id), 64'd7);
        check_val("p1_x", 64'(sprite_queue_sprite_x), 64'd400);
        check_val("p1_y", 64'(sprite_queue_sprite_y), 64'd200);
        check_val("p1_scale", 64'(sprite_queue_sprite_scale), 64'd16);
        check_val("p1_count", 64'(queue_count), 64'd1);
        pop_one();
        check_val("p1_drained", 64'(sprite_queue_is_empty), 64'd1);

        // Junk bytes before a header, then a packet whose payload contains A5
        send_byte(8'h00);
        send_byte(8'hFF);
        send_pkt(8'h03, 16'd10, 16'd20, 8'd1);
        send_pkt(8'hA5, 16'h1234, 16'h00A5, 8'h05);
        check_val("p2_ferr", 64'(frame_err_cnt), 64'd2);
        check_val("p2_count", 64'(queue_count), 64'd2);
        check_val("p2_head", 64'(head), 64'({8'd3, 16'd10, 16'd20, 8'd1}));
        pop_one();
        check_val("p3_head", 64'(head), 64'({8'hA5, 16'h1234, 16'h00A5, 8'h05}));
        pop_one();
        check_val("p3_drained", 64'(sprite_queue_is_empty), 64'd1);

        // Fill to DEPTH, then stall the final byte of packet 65
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_pkt(8'(i + 1), 16'(i * 3), 16'(1000 + i), 8'(i));
        check_val("full_count", 64'(queue_count), 64'd64);
        check_val("full_ready_hunt", 64'(in_ready), 64'd1);
        send_byte(8'hA5);
        send_byte(8'd65);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        in_valid = 1'b1;
        in_data  = 8'h41;
        check_val("full_stall", 64'(in_ready), 64'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check_val("full_stall_hold", 64'(in_ready), 64'd0);
        check_val("full_stall_count", 64'(queue_count), 64'd64);
        pop_one();
        check_val("full_ready_after_pop", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check_val("full_refill_count", 64'(queue_count), 64'd64);
        check_val("full_head_pkt2", 64'(head), 64'({8'd2, 16'd3, 16'd1001, 8'd1}));
        for (int i = 1; i < DEPTH; i++) begin
            check_val($sformatf("drain%0d", i), 64'(head), 64'({8'(i + 1), 16'(i * 3), 16'(1000 + i), 8'(i)}));
            pop_one();
        end
        check_val("drain_pkt65", 64'(head), 64'({8'd65, 16'd0, 16'd0, 8'h41}));
        pop_one();
        check_val("drain_empty", 64'(sprite_queue_is_empty), 64'd1);

        // Back-to-back dequeues, then one on an empty queue
        for (int i = 1; i <= 3; i++) send_pkt(8'(i), 16'(i), 16'(i), 8'(i));
        sprite_queue_dequeue = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check_val($sformatf("b2b_head%0d", k), 64'(sprite_queue_sprite_id), 64'(k));
            @(posedge clock);
            #1;
        end
        sprite_queue_dequeue = 1'b0;
        check_val("b2b_empty", 64'(sprite_queue_is_empty), 64'd1);
        check_val("b2b_no_under", 64'(underflow), 64'd0);
        pop_one();
        check_val("b2b_under", 64'(underflow), 64'd1);
        check_val("b2b_count", 64'(queue_count), 64'd0);

        // Asynchronous flush mid-packet with entries queued
        do_reset();
        for (int i = 0; i < 5; i++) send_pkt(8'(i), 16'(i), 16'(i), 8'(i));
        check_val("flush_pre_count", 64'(queue_count), 64'd5);
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        #2;
        fb_resetting = 1'b1;
        #1;
        check_val("flush_empty", 64'(sprite_queue_is_empty), 64'd1);
        check_val("flush_count", 64'(queue_count), 64'd0);
        @(negedge clock);
        fb_resetting = 1'b0;
        @(posedge clock);
        #1;
        send_pkt(8'h5A, 16'h1234, 16'hABCD, 8'h7F);
        check_val("flush_next_head", 64'(head), 64'({8'h5A, 16'h1234, 16'hABCD, 8'h7F}));
        check_val("flush_next_count", 64'(queue_count), 64'd1);
        check_val("flush_next_ferr", 64'(frame_err_cnt), 64'd0);

        // Random soak against the model
        do_reset();
        exp_q.delete();
        m_collect = 1'b0;
        m_idx     = 0;
        m_buf     = '0;
        m_err     = 0;
        m_under   = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            if (cyc < 4000) dq = ($urandom_range(0, 19) == 0);
            else if (cyc < 7000) dq = ($urandom_range(0, 9) < 3);
            else dq = ($urandom_range(0, 9) == 0);
            sprite_queue_dequeue = dq;
            m_ready = !(m_collect && m_idx == 5 && exp_q.size() == DEPTH);
            check_val("soak_status",
                      64'({in_ready, sprite_queue_is_empty, queue_count, underflow, frame_err_cnt}),
                      64'({m_ready, exp_q.size() == 0, 7'(exp_q.size()), m_under, 8'(m_err)}));
            if (exp_q.size() != 0) check_val("soak_head", 64'(head), 64'(exp_q[0]));
            if (dq) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                else m_under = 1'b1;
            end
            acc = in_valid && m_ready;
            b   = in_data;
            if (acc) begin
                if (!m_collect) begin
                    if (b == 8'hA5) begin
                        m_collect = 1'b1;
                        m_idx     = 0;
                    end else if (m_err < 255) begin
                        m_err++;
                    end
                end else if (m_idx == 5) begin
                    exp_q.push_back({m_buf, b});
                    m_collect = 1'b0;
                    m_idx     = 0;
                end else begin
                    m_buf = {m_buf[31:0], b};
                    m_idx++;
                end
            end
            @(posedge clock);
            #1;
        end
        in_valid             = 1'b0;
        sprite_queue_dequeue = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
